// File: rtl/pipe_stage_reg_pkg.sv
// pipe_stage_reg_pkg: shared pipeline constants (payload field indices, exception vector)
package pipe_stage_reg_pkg;
    localparam logic [31:0] EXC_PC_DEFAULT = 32'hBFC00380;
    localparam int FIELD_INSTR = 0;
    localparam int FIELD_PC    = 1;
    localparam int FIELD_PC8   = 2;
    localparam int FIELD_ALU   = 3;
    localparam int FIELD_MDU   = 4;
endpackage

// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if: upstream/downstream handshake and payload bundle for one pipeline stage
interface pipe_stage_reg_if #(
    parameter int DATA_W     = 32,
    parameter int NUM_FIELDS = 5,
    parameter int NUM_LATE   = 2
);
    logic                         in_valid;
    logic                         in_ready;
    logic [NUM_FIELDS*DATA_W-1:0] in_fields;
    logic [NUM_LATE*DATA_W-1:0]   in_late;
    logic                         flush;
    logic                         req;
    logic                         out_valid;
    logic                         out_ready;
    logic [NUM_FIELDS*DATA_W-1:0] out_fields;
    logic [NUM_LATE*DATA_W-1:0]   out_late;
    logic                         late_held;
    modport master (
        output in_valid, in_fields, in_late, flush, req, out_ready,
        input  in_ready, out_valid, out_fields, out_late, late_held
    );
    modport slave (
        input  in_valid, in_fields, in_late, flush, req, out_ready,
        output in_ready, out_valid, out_fields, out_late, late_held
    );
endinterface

// File: rtl/pipe_stage_reg_late_hold.sv
// late_hold: freezes late-arriving payload while the stage is stalled downstream
module late_hold #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         capture,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         held
);
    logic [W-1:0] hold_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            held   <= 1'b0;
            hold_q <= '0;
        end else if (clear) begin
            held <= 1'b0;
        end else if (capture && !held) begin
            hold_q <= d;
            held   <= 1'b1;
        end
    end
    assign q = held ? hold_q : d;
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: single-entry pipeline register with flush/exception bubbles and late-word hold
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int          DATA_W     = 32,
    parameter int          NUM_FIELDS = 5,
    parameter int          NUM_LATE   = 2,
    parameter int          PC_FIELD   = FIELD_PC,
    parameter logic [31:0] EXC_PC     = EXC_PC_DEFAULT,
    parameter bit          LATE_HOLD  = 1'b1
) (
    input logic              clk,
    input logic              reset,
    pipe_stage_reg_if.slave  bus
);
    logic                         valid_q;
    logic [NUM_FIELDS*DATA_W-1:0] fields_q;
    logic                         load;
    assign bus.in_ready   = !valid_q | bus.out_ready;
    assign load           = bus.in_valid & bus.in_ready;
    assign bus.out_valid  = valid_q;
    assign bus.out_fields = fields_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q  <= 1'b0;
            fields_q <= '0;
        end else if (bus.req) begin
            valid_q  <= 1'b0;
            fields_q <= '0;
            fields_q[PC_FIELD*DATA_W +: DATA_W] <= DATA_W'(EXC_PC);
        end else if (bus.flush) begin
            valid_q  <= 1'b0;
            fields_q <= '0;
        end else if (load) begin
            valid_q  <= 1'b1;
            fields_q <= bus.in_fields;
        end else if (bus.out_ready) begin
            valid_q  <= 1'b0;
        end
    end
    // a load while stalled is impossible, so capture never races a clear
    if (LATE_HOLD) begin : g_hold
        logic capture, clear;
        assign capture = valid_q & !bus.out_ready & !bus.req & !bus.flush;
        assign clear   = bus.req | bus.flush | load | (valid_q & bus.out_ready);
        late_hold #(.W(NUM_LATE*DATA_W)) u_late_hold (
            .clk     (clk),
            .reset   (reset),
            .capture (capture),
            .clear   (clear),
            .d       (bus.in_late),
            .q       (bus.out_late),
            .held    (bus.late_held)
        );
    end else begin : g_pass
        assign bus.out_late  = bus.in_late;
        assign bus.late_held = 1'b0;
    end
endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of every payload word.
REQ-002 SHALL have parameter NUM_FIELDS, default 5, count of early payload words registered at load (instr, pc, pc8, alu, mdu).
REQ-003 SHALL have parameter NUM_LATE, default 2, count of late words arriving one cycle after load (memory read data, cp0 read data).
REQ-004 SHALL have parameter PC_FIELD, default 1, index of the field overwritten on exception.
REQ-005 SHALL have parameter EXC_PC, default 32'hBFC00380, value written into PC_FIELD on exception.
REQ-006 SHALL have parameter LATE_HOLD, default 1; 1 enables late-word capture, 0 makes out_late a pure pass-through.
REQ-007 clk  input  1  single clock, all state on rising edge.
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 in_valid  input  1  upstream word set valid.
REQ-010 in_ready  output  1  stage can accept this cycle.
REQ-011 in_fields  input  NUM_FIELDS*DATA_W  early payload; field i at bits [i*DATA_W +: DATA_W].
REQ-012 in_late  input  NUM_LATE*DATA_W  late payload, valid in the cycle after load.
REQ-013 flush  input  1  kill stage contents, insert bubble.
REQ-014 req  input  1  exception/interrupt request; insert bubble tagged with EXC_PC.
REQ-015 out_valid  output  1  stage holds a live entry.
REQ-016 out_ready  input  1  downstream accepts.
REQ-017 out_fields  output  NUM_FIELDS*DATA_W  registered early payload.
REQ-018 out_late  output  NUM_LATE*DATA_W  late payload, live or held.
REQ-019 late_held  output  1  out_late is sourced from the hold register.

Function
REQ-020 in_ready SHALL equal !out_valid | out_ready, combinational, no skid entry.
REQ-021 Load SHALL occur on an edge with in_valid & in_ready: out_fields <= in_fields, out_valid <= 1.
REQ-022 On an edge with out_valid & out_ready and no load, out_valid SHALL clear; out_fields SHALL keep their value.
REQ-023 Per-edge priority SHALL be: req > flush > load > drain > hold.
REQ-024 req SHALL set out_valid <= 0, all fields <= 0 except PC_FIELD <= EXC_PC[DATA_W-1:0], clear late_held, regardless of in_valid/out_ready.
REQ-025 flush (without req) SHALL set out_valid <= 0, all fields <= 0, clear late_held.
REQ-026 With LATE_HOLD=1: on an edge where out_valid & !out_ready & !late_held and no req/flush, the hold register SHALL capture in_late and late_held SHALL set.
REQ-027 While late_held=1 the hold register SHALL not change, even if in_late changes.
REQ-028 late_held SHALL clear on any load, drain, req, or flush; capture and clear in the same edge is impossible (REQ-026 requires !out_ready).
REQ-029 out_late SHALL equal late_held ? hold register : in_late, combinationally.
REQ-030 With LATE_HOLD=0, late_held SHALL be constant 0 and the hold register SHALL not be instantiated.
REQ-031 Load-to-out_fields latency SHALL be one cycle; in_ready-from-out_ready path SHALL be combinational, with no other combinational in-to-out path except in_late to out_late.
REQ-032 All NUM_LATE words SHALL be captured together by one shared late_held flag.

Reset
REQ-033 reset SHALL asynchronously force out_valid=0, out_fields=0, hold register=0, late_held=0; in_ready=1 during reset.
REQ-034 Reset asserted mid-stall SHALL discard held late data; first post-reset out_late SHALL be in_late.

Structure
REQ-035 EXC_PC default and the field-index constants (FIELD_INSTR=0, FIELD_PC=1, FIELD_PC8=2, FIELD_ALU=3, FIELD_MDU=4) SHALL live in the shared pipeline package.
REQ-036 Late-capture logic SHALL be one sub-module, late_hold, parametrised by DATA_W*NUM_LATE, generated only when LATE_HOLD=1.

Verification
REQ-037 Load pc=0x00003000, out_ready=1 -> next cycle out_valid=1, out_fields[PC]=0x00003000, out_late tracks in_late, late_held=0.
REQ-038 Load, then out_ready=0 for 3 cycles, in_late=0x11 at first stall edge, 0x22 after -> late_held=1, out_late=0x11 throughout; on out_ready=1 drain, late_held=0.
REQ-039 req and flush asserted together while stalled with valid entry -> out_valid=0, out_fields[PC]=0xBFC00380, others 0, late_held=0.
REQ-040 flush alone with in_valid=1, in_ready=1 -> out_valid=0, all fields 0, input word dropped.
REQ-041 Back-to-back loads 4 cycles with out_ready=1 -> one word per cycle, in_ready constant 1, late_held never set.
REQ-042 reset pulsed asynchronously mid-cycle during held stall -> outputs zero immediately, late_held=0, out_late=in_late after release.
